// File: rtl/lc3b_types.sv
// Shared LC-3b types: opcode and ALU function encodings, plus the control FSM states.
package lc3b_types;

  typedef enum logic [3:0] {
    op_br   = 4'b0000,
    op_add  = 4'b0001,
    op_ldb  = 4'b0010,
    op_stb  = 4'b0011,
    op_jsr  = 4'b0100,
    op_and  = 4'b0101,
    op_ldr  = 4'b0110,
    op_str  = 4'b0111,
    op_rti  = 4'b1000,
    op_not  = 4'b1001,
    op_ldi  = 4'b1010,
    op_sti  = 4'b1011,
    op_jmp  = 4'b1100,
    op_shf  = 4'b1101,
    op_lea  = 4'b1110,
    op_trap = 4'b1111
  } lc3b_opcode;

  typedef enum logic [2:0] {
    alu_add,
    alu_and,
    alu_not,
    alu_pass,
    alu_sll,
    alu_srl,
    alu_sra
  } lc3b_aluop;

  typedef enum logic [4:0] {
    FETCH1, FETCH2, FETCH3, DECODE,
    S_ADD, S_AND, S_NOT,
    BR, BR_TAKEN, JMP, LEA,
    CALC_ADDR, LDR1, LDR2, STR1, STR2
  } lc3b_ctrl_state;

endpackage

// File: rtl/mem_watchdog.sv
// Memory wait watchdog: counts stalled cycles in a wait state and aborts at the limit.
module mem_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic wait_i,
  input  logic mem_resp_i,
  output logic timeout_o,
  output logic mem_error_o
);
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q;

  // The response on the limit cycle completes normally, so it masks the timeout.
  assign timeout_o   = wait_i && !mem_resp_i && (cnt_q >= CW'(TIMEOUT_CYCLES - 1));
  assign cnt_d       = (wait_i && !mem_resp_i && !timeout_o) ? cnt_q + CW'(1) : '0;
  assign mem_error_o = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= timeout_o;
    end
  end
endmodule

// File: rtl/control.sv
// LC-3b multicycle control FSM; outputs decode from state and datapath status.
// Optional memory timeout watchdog enabled by CONTROL_MEM_TIMEOUT_EN.
module control
  import lc3b_types::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  lc3b_opcode opcode,
  input  logic       branch_enable,
  input  logic       imm5_enable,
  input  logic       imm11_enable,
  input  logic       mem_resp,
  output logic [1:0] pcmux_sel,
  output logic [1:0] alumux_sel,
  output logic [1:0] regfilemux_sel,
  output logic       storemux_sel,
  output logic       marmux_sel,
  output logic       mdrmux_sel,
  output logic       load_pc,
  output logic       load_ir,
  output logic       load_regfile,
  output logic       load_mar,
  output logic       load_mdr,
  output logic       load_cc,
  output lc3b_aluop  aluop,
  output logic       mem_read,
  output logic       mem_write,
  output logic [1:0] mem_byte_enable,
  output logic       mem_error
);
  lc3b_ctrl_state state_q, state_d;
  logic           in_wait, timeout, unused_ok;

  assign in_wait = (state_q == FETCH2) || (state_q == LDR1) || (state_q == STR2);

`ifdef CONTROL_MEM_TIMEOUT_EN
  logic wd_err;

  mem_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wd (
    .clk        (clk),
    .rst        (rst),
    .wait_i     (in_wait),
    .mem_resp_i (mem_resp),
    .timeout_o  (timeout),
    .mem_error_o(wd_err)
  );
  assign mem_error = wd_err && !rst;
  assign unused_ok = imm11_enable;
`else
  assign timeout   = 1'b0;
  assign mem_error = 1'b0;
  assign unused_ok = ^{imm11_enable, in_wait, 32'(TIMEOUT_CYCLES)};
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH1:    state_d = FETCH2;
      FETCH2:    if (mem_resp) state_d = FETCH3; else if (timeout) state_d = FETCH1;
      FETCH3:    state_d = DECODE;
      DECODE: begin
        case (opcode)
          op_add:         state_d = S_ADD;
          op_and:         state_d = S_AND;
          op_not:         state_d = S_NOT;
          op_br:          state_d = BR;
          op_jmp:         state_d = JMP;
          op_lea:         state_d = LEA;
          op_ldr, op_str: state_d = CALC_ADDR;
          default:        state_d = FETCH1;
        endcase
      end
      BR:        state_d = branch_enable ? BR_TAKEN : FETCH1;
      CALC_ADDR: state_d = (opcode == op_str) ? STR1 : LDR1;
      LDR1:      if (mem_resp) state_d = LDR2; else if (timeout) state_d = FETCH1;
      STR1:      state_d = STR2;
      STR2:      if (mem_resp || timeout) state_d = FETCH1;
      default:   state_d = FETCH1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= FETCH1;
    else     state_q <= state_d;
  end

  // Reset masks every state-driven deviation so no strobe escapes mid-access.
  always_comb begin
    pcmux_sel       = 2'd0;
    alumux_sel      = 2'd0;
    regfilemux_sel  = 2'd0;
    storemux_sel    = 1'b0;
    marmux_sel      = 1'b0;
    mdrmux_sel      = 1'b0;
    load_pc         = 1'b0;
    load_ir         = 1'b0;
    load_regfile    = 1'b0;
    load_mar        = 1'b0;
    load_mdr        = 1'b0;
    load_cc         = 1'b0;
    aluop           = alu_add;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_byte_enable = 2'b11;
    if (!rst) begin
      unique case (state_q)
        FETCH1: begin
          marmux_sel = 1'b1;
          load_mar   = 1'b1;
          load_pc    = 1'b1;
        end
        FETCH2, LDR1: begin
          mem_read   = 1'b1;
          mdrmux_sel = 1'b1;
          load_mdr   = 1'b1;
        end
        FETCH3: load_ir = 1'b1;
        S_ADD, S_AND: begin
          aluop        = (state_q == S_AND) ? alu_and : alu_add;
          alumux_sel   = imm5_enable ? 2'd2 : 2'd0;
          load_regfile = 1'b1;
          load_cc      = 1'b1;
        end
        S_NOT: begin
          aluop        = alu_not;
          load_regfile = 1'b1;
          load_cc      = 1'b1;
        end
        BR_TAKEN: begin
          pcmux_sel = 2'd1;
          load_pc   = 1'b1;
        end
        JMP: begin
          pcmux_sel = 2'd2;
          load_pc   = 1'b1;
        end
        LEA: begin
          regfilemux_sel = 2'd2;
          load_regfile   = 1'b1;
          load_cc        = 1'b1;
        end
        CALC_ADDR: begin
          alumux_sel = 2'd1;
          load_mar   = 1'b1;
        end
        LDR2: begin
          regfilemux_sel = 2'd1;
          load_regfile   = 1'b1;
          load_cc        = 1'b1;
        end
        STR1: begin
          storemux_sel = 1'b1;
          aluop        = alu_pass;
          load_mdr     = 1'b1;
        end
        STR2:    mem_write = 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_control.sv
// Directed bench for control: walks each instruction class cycle by cycle against hand-built output vectors.
module tb_control;
  import lc3b_types::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  lc3b_opcode opcode = op_add;
  logic       branch_enable = 1'b0, imm5_enable = 1'b0, imm11_enable = 1'b0, mem_resp = 1'b0;
  logic [1:0] pcmux_sel, alumux_sel, regfilemux_sel, mem_byte_enable;
  logic       storemux_sel, marmux_sel, mdrmux_sel;
  logic       load_pc, load_ir, load_regfile, load_mar, load_mdr, load_cc;
  lc3b_aluop  aluop;
  logic       mem_read, mem_write, mem_error;

  int n_tests = 0;
  int n_fail  = 0;

  control #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .branch_enable(branch_enable),
    .imm5_enable(imm5_enable), .imm11_enable(imm11_enable), .mem_resp(mem_resp),
    .pcmux_sel(pcmux_sel), .alumux_sel(alumux_sel), .regfilemux_sel(regfilemux_sel),
    .storemux_sel(storemux_sel), .marmux_sel(marmux_sel), .mdrmux_sel(mdrmux_sel),
    .load_pc(load_pc), .load_ir(load_ir), .load_regfile(load_regfile),
    .load_mar(load_mar), .load_mdr(load_mdr), .load_cc(load_cc), .aluop(aluop),
    .mem_read(mem_read), .mem_write(mem_write), .mem_byte_enable(mem_byte_enable),
    .mem_error(mem_error)
  );

  always #5 clk = ~clk;

  logic [22:0] outs;
  assign outs = {pcmux_sel, alumux_sel, regfilemux_sel, storemux_sel, marmux_sel, mdrmux_sel,
                 load_pc, load_ir, load_regfile, load_mar, load_mdr, load_cc, aluop,
                 mem_read, mem_write, mem_byte_enable, mem_error};

  function automatic logic [22:0] o(input logic [1:0] pc, input logic [1:0] alu,
                                    input logic [1:0] rf, input logic st, input logic mar,
                                    input logic mdr, input logic lpc, input logic lir,
                                    input logic lrf, input logic lmar, input logic lmdr,
                                    input logic lcc, input lc3b_aluop op, input logic rd,
                                    input logic wr, input logic err);
    return {pc, alu, rf, st, mar, mdr, lpc, lir, lrf, lmar, lmdr, lcc, op, rd, wr, 2'b11, err};
  endfunction

  logic [22:0] E_IDLE, E_F1, E_F2, E_F3, E_ADDI, E_ADDR, E_ANDI, E_NOT, E_BRT, E_JMP, E_LEA;
  logic [22:0] E_CALC, E_LDR2, E_STR1, E_STR2, E_ERR;

  task automatic chk(input string tag, input logic [22:0] obs, input logic [22:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %06h expected %06h", tag, obs, exp);
    end
  endtask

  // Drive mem_resp for the current cycle, check outputs, then advance one clock.
  task automatic cyc(input string tag, input logic resp, input logic [22:0] exp);
    mem_resp = resp;
    #1;
    chk(tag, outs, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input lc3b_opcode op, input int waits);
    opcode = op;
    cyc("fetch1", 1'b0, E_F1);
    for (int i = 0; i < waits; i++) cyc("fetch2_wait", 1'b0, E_F2);
    cyc("fetch2_resp", 1'b1, E_F2);
    cyc("fetch3", 1'b0, E_F3);
    cyc("decode", 1'b0, E_IDLE);
  endtask

  initial begin
    E_IDLE = o(0,0,0, 0,0,0, 0,0,0,0,0,0, alu_add,  0,0,0);
    E_F1   = o(0,0,0, 0,1,0, 1,0,0,1,0,0, alu_add,  0,0,0);
    E_F2   = o(0,0,0, 0,0,1, 0,0,0,0,1,0, alu_add,  1,0,0);
    E_F3   = o(0,0,0, 0,0,0, 0,1,0,0,0,0, alu_add,  0,0,0);
    E_ADDI = o(0,2,0, 0,0,0, 0,0,1,0,0,1, alu_add,  0,0,0);
    E_ADDR = o(0,0,0, 0,0,0, 0,0,1,0,0,1, alu_add,  0,0,0);
    E_ANDI = o(0,2,0, 0,0,0, 0,0,1,0,0,1, alu_and,  0,0,0);
    E_NOT  = o(0,0,0, 0,0,0, 0,0,1,0,0,1, alu_not,  0,0,0);
    E_BRT  = o(1,0,0, 0,0,0, 1,0,0,0,0,0, alu_add,  0,0,0);
    E_JMP  = o(2,0,0, 0,0,0, 1,0,0,0,0,0, alu_add,  0,0,0);
    E_LEA  = o(0,0,2, 0,0,0, 0,0,1,0,0,1, alu_add,  0,0,0);
    E_CALC = o(0,1,0, 0,0,0, 0,0,0,1,0,0, alu_add,  0,0,0);
    E_LDR2 = o(0,0,1, 0,0,0, 0,0,1,0,0,1, alu_add,  0,0,0);
    E_STR1 = o(0,0,0, 1,0,0, 0,0,0,0,1,0, alu_pass, 0,0,0);
    E_STR2 = o(0,0,0, 0,0,0, 0,0,0,0,0,0, alu_add,  0,1,0);
    E_ERR  = o(0,0,0, 0,1,0, 1,0,0,1,0,0, alu_add,  0,0,1);

    @(posedge clk); #1;
    chk("reset_defaults", outs, E_IDLE);
    @(posedge clk); #1;
    rst = 1'b0;

    // Reset during a pending instruction fetch.
    cyc("pre_rst_f1", 1'b0, E_F1);
    cyc("pre_rst_f2", 1'b0, E_F2);
    rst = 1'b1;
    #1;
    chk("rst_mid_fetch", outs, E_IDLE);
    @(posedge clk); #1;
    chk("rst_held", outs, E_IDLE);
    @(posedge clk); #1;
    rst = 1'b0;

    // ADD with imm5 (0x1261), then register ADD, AND imm, NOT.
    imm5_enable = 1'b1;
    fetch(op_add, 0);
    cyc("add_imm5", 1'b0, E_ADDI);
    imm5_enable = 1'b0;
    fetch(op_add, 1);
    cyc("add_reg", 1'b0, E_ADDR);
    imm5_enable = 1'b1;
    fetch(op_and, 0);
    cyc("and_imm5", 1'b0, E_ANDI);
    imm5_enable = 1'b0;
    fetch(op_not, 0);
    cyc("not", 1'b0, E_NOT);

    // Branch not taken returns straight to FETCH1; taken adds BR_TAKEN.
    branch_enable = 1'b0;
    fetch(op_br, 0);
    cyc("br_not_taken", 1'b0, E_IDLE);
    branch_enable = 1'b1;
    fetch(op_br, 0);
    cyc("br_eval", 1'b0, E_IDLE);
    cyc("br_taken", 1'b0, E_BRT);
    branch_enable = 1'b0;

    fetch(op_jmp, 0);
    cyc("jmp", 1'b0, E_JMP);
    fetch(op_lea, 0);
    cyc("lea", 1'b0, E_LEA);

    // LDR with 3 wait cycles on the data access: mem_read for 4 cycles.
    fetch(op_ldr, 0);
    cyc("ldr_calc", 1'b0, E_CALC);
    for (int i = 0; i < 3; i++) cyc("ldr1_wait", 1'b0, E_F2);
    cyc("ldr1_resp", 1'b1, E_F2);
    cyc("ldr2", 1'b0, E_LDR2);

    // STR: write held until response.
    fetch(op_str, 0);
    cyc("str_calc", 1'b0, E_CALC);
    cyc("str1", 1'b0, E_STR1);
    cyc("str2_wait", 1'b0, E_STR2);
    cyc("str2_wait", 1'b0, E_STR2);
    cyc("str2_resp", 1'b1, E_STR2);

    // Unsupported opcode: DECODE back to FETCH1.
    fetch(op_trap, 0);

    // Response outside a wait state is ignored.
    cyc("stray_resp_f1", 1'b1, E_F1);
    cyc("stray_f2", 1'b0, E_F2);
    cyc("stray_f2_hold", 1'b0, E_F2);
    cyc("stray_f2_resp", 1'b1, E_F2);
    cyc("stray_f3", 1'b0, E_F3);
    opcode = op_lea;
    cyc("stray_decode", 1'b0, E_IDLE);
    cyc("stray_lea", 1'b0, E_LEA);

`ifdef CONTROL_MEM_TIMEOUT_EN
    // Limit 4: four stalled cycles abort, error pulses in the following FETCH1.
    cyc("to_f1", 1'b0, E_F1);
    for (int i = 0; i < 4; i++) cyc("to_f2_wait", 1'b0, E_F2);
    cyc("to_error_pulse", 1'b0, E_ERR);
    for (int i = 0; i < 3; i++) cyc("to_edge_wait", 1'b0, E_F2);
    cyc("to_edge_resp", 1'b1, E_F2);
    cyc("to_edge_f3", 1'b0, E_F3);
    opcode = op_not;
    cyc("to_edge_decode", 1'b0, E_IDLE);
    cyc("to_edge_not", 1'b0, E_NOT);
    cyc("to_after_f1", 1'b0, E_F1);
`else
    // Without the watchdog a long stall just waits.
    cyc("long_f1", 1'b0, E_F1);
    for (int i = 0; i < 8; i++) cyc("long_f2_wait", 1'b0, E_F2);
    cyc("long_f2_resp", 1'b1, E_F2);
    cyc("long_f3", 1'b0, E_F3);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end
endmodule

// File: doc/control.md
# control

Multicycle sequencer for the LC-3b datapath. It is a Moore-style FSM that fetches, decodes and executes one instruction at a time by driving every datapath control input. It handshakes with single-port memory using `mem_read`/`mem_write` and `mem_resp`. It sits beside the datapath inside the CPU top and consumes `opcode`, `branch_enable`, `imm5_enable` and `imm11_enable`.

## Interface
- `TIMEOUT_CYCLES`, default 255: memory wait limit. Used only when the watchdog is compiled in.
- `clk` input 1: system clock; all state changes on its rising edge.
- `rst` input 1: reset, synchronous and active-high; forces state `FETCH1`.
- `opcode` input lc3b_opcode: IR opcode field.
- `branch_enable`, `imm5_enable`, `imm11_enable` input 1 each: datapath status.
- `mem_resp` input 1: memory done, valid in the cycle it is high.
- `pcmux_sel`, `alumux_sel`, `regfilemux_sel` output 2 each: datapath mux selects.
- `storemux_sel`, `marmux_sel`, `mdrmux_sel` output 1 each: datapath mux selects.
- `load_pc`, `load_ir`, `load_regfile`, `load_mar`, `load_mdr`, `load_cc` output 1 each: register loads.
- `aluop` output lc3b_aluop: ALU function.
- `mem_read`, `mem_write` output 1 each: memory strobes.
- `mem_byte_enable` output 2: always 2'b11.
- `mem_error` output 1: one-cycle pulse when a memory access is aborted.

## Operation
- Default output values: all loads, strobes and selects 0; `aluop` = alu_add; `mem_byte_enable` = 2'b11. A state drives only the deviations listed below.
- Mux encodings:
  - pcmux: 0 = PC+2, 1 = br_add, 2 = SR1.
  - alumux: 0 = SR2, 1 = adj6, 2 = sext(imm5).
  - regfilemux: 0 = ALU, 1 = MDR, 2 = br_add.
  - marmux: 0 = ALU, 1 = PC.
  - mdrmux: 0 = ALU, 1 = mem_rdata.
  - storemux: 0 = SR1 field, 1 = DEST field.
- States and the outputs each one drives:
  - `FETCH1`: `marmux_sel`=1, `load_mar`, `pcmux_sel`=0, `load_pc`.
  - `FETCH2`: `mem_read`, `mdrmux_sel`=1, `load_mdr`. Stays until `mem_resp`.
  - `FETCH3`: `load_ir`.
  - `DECODE`: no outputs.
  - `S_ADD` / `S_AND`: `aluop` add/and, `alumux_sel` = `imm5_enable` ? 2 : 0, `regfilemux_sel`=0, `load_regfile`, `load_cc`.
  - `S_NOT`: `aluop` = alu_not, `load_regfile`, `load_cc`.
  - `BR`: no outputs. Goes to `BR_TAKEN` if `branch_enable`, else `FETCH1`.
  - `BR_TAKEN`: `pcmux_sel`=1, `load_pc`.
  - `JMP`: `pcmux_sel`=2, `load_pc`.
  - `LEA`: `regfilemux_sel`=2, `load_regfile`, `load_cc`.
  - `CALC_ADDR`: `alumux_sel`=1, `aluop` add, `marmux_sel`=0, `load_mar`.
  - `LDR1`: `mem_read`, `mdrmux_sel`=1, `load_mdr`. Waits for `mem_resp`.
  - `LDR2`: `regfilemux_sel`=1, `load_regfile`, `load_cc`.
  - `STR1`: `storemux_sel`=1, `aluop` = alu_pass, `mdrmux_sel`=0, `load_mdr`.
  - `STR2`: `mem_write`. Waits for `mem_resp`.
- DECODE dispatch: op_add→S_ADD, op_and→S_AND, op_not→S_NOT, op_br→BR, op_jmp→JMP, op_lea→LEA, op_ldr/op_str→CALC_ADDR. CALC_ADDR then goes to LDR1 or STR1 according to the latched opcode.
- Every other opcode goes DECODE→FETCH1 with no side effects.
- Every execute-terminal state returns to FETCH1.
- `imm11_enable` is ignored in this revision.

## Timing
- Outputs are combinational from the current state and datapath status only. No output depends combinationally on `mem_resp`, except the transition.
- `rst` high at a clock edge puts the FSM in FETCH1 on the next cycle, including mid-access. While `rst` is high, all outputs are forced to their default values, so no strobe is seen.
- `mem_read` and `mem_write` stay high continuously from entry into a wait state until the cycle `mem_resp` is high. The FSM leaves the state on that edge.
- `load_mdr` stays high throughout FETCH2/LDR1; the final capture is the data valid with `mem_resp`.
- Instruction latency with a 1-cycle memory:
  - ADD/AND/NOT/LEA/JMP: 5 cycles.
  - BR not taken: 5 cycles; BR taken: 6 cycles.
  - LDR and STR: 7 cycles.
  - Each extra memory wait cycle adds 1.
- `mem_resp` seen outside a wait state is ignored.

## Configuration
- `CONTROL_MEM_TIMEOUT_EN` defined:
  - A wait counter clears on entry to FETCH2, LDR1 or STR2 and increments each cycle without `mem_resp`.
  - When the count reaches `TIMEOUT_CYCLES`, the strobe drops, `mem_error` pulses for 1 cycle and the FSM goes to FETCH1.
  - PC has already advanced, so the instruction is skipped.
  - `mem_resp` in the same cycle as the limit is reached wins: normal completion, no error.
- Not defined: the FSM waits indefinitely, `mem_error` is tied 0 and the counter is absent.

## Structure
- `lc3b_types` gains the `lc3b_ctrl_state` enum covering all states above.
- Existing `lc3b_opcode` and `lc3b_aluop` are reused.
- One sub-module, `mem_watchdog`, holds the timeout counter and `mem_error` generation. It is instantiated only under `CONTROL_MEM_TIMEOUT_EN`.

## Test plan
- Reset mid-fetch: `rst` high during FETCH2 with `mem_read`=1 → next cycle `mem_read`=0; after `rst` falls, FETCH1 drives `load_mar`=1 and `load_pc`=1.
- ADD with imm5: memory returns 0x1261 after 0 wait → `alumux_sel`=2, `aluop` add, `load_regfile`=`load_cc`=1 in cycle 5, then FETCH1.
- BR taken vs not: `branch_enable`=1 → `pcmux_sel`=1 and `load_pc` in cycle 6; `branch_enable`=0 → FETCH1 after cycle 5, no `load_pc`.
- LDR with 3 wait cycles on the data access → `mem_read` held exactly 4 cycles in LDR1, then `regfilemux_sel`=1 and `load_regfile`.
- STR → STR1 drives `storemux_sel`=1 and alu_pass; `mem_write` is held until `mem_resp`, then FETCH1.
- Timeout (macro on, `TIMEOUT_CYCLES`=4, `mem_resp` never asserted) → `mem_error` pulses once and FETCH1 is re-entered. With `mem_resp` on the 4th cycle → no error.
